// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the instruction memory and
// fills the IF/ID register; a misaligned redirect parks the stage in a sticky fault.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] f_imem_A,
  input  logic [31:0] f_imem_RD,
  input  logic        f_stall,
  input  logic        f_flush,
  input  logic        f_redirect,
  input  logic [31:0] f_target,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pcplus4,
  output logic        d_valid,
  output logic        f_fault
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_dpc;
  logic [31:0] r_dpc4;
  logic        r_valid;
  logic        r_fault;
  logic [31:0] w_pc_plus4;
  logic        w_misaligned;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_misaligned = (f_target[1:0] != 2'b00);

  // PC, IF/ID register and fault FSM; redirect outranks flush, flush outranks stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_dpc   <= 32'h0000_0000;
      r_dpc4  <= 32'h0000_0000;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (f_redirect) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            if (w_misaligned) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc <= f_target;
            end
          end else if (f_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            if (!f_stall) begin
              r_pc <= w_pc_plus4;
            end
          end else if (!f_stall) begin
            r_instr <= f_imem_RD;
            r_dpc   <= r_pc;
            r_dpc4  <= w_pc_plus4;
            r_valid <= 1'b1;
            r_pc    <= w_pc_plus4;
          end
        end
        ST_FAULT: begin
          r_valid <= 1'b0;
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= ST_BOOT;
          r_pc    <= RESET_PC;
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign f_imem_A  = r_pc;
  assign d_instr   = r_instr;
  assign d_pc      = r_dpc;
  assign d_pcplus4 = r_dpc4;
  assign d_valid   = r_valid;
  assign f_fault   = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a default-PC instance and a wrap-around instance
// share stimulus; expected outputs are queued per cycle and compared after each edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct packed {
    logic        f;
    logic        v;
    logic [31:0] a;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redir;
  logic [31:0] target;
  logic [31:0] a0, rd0, instr0, pc0, pc40;
  logic        v0, f0;
  logic [31:0] a1, rd1, instr1, pc1, pc41;
  logic        v1, f1;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] addr);
    return {addr[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  assign rd0 = mem(a0);
  assign rd1 = mem(a1);

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .f_imem_A(a0), .f_imem_RD(rd0),
    .f_stall(stall), .f_flush(flush), .f_redirect(redir), .f_target(target),
    .d_instr(instr0), .d_pc(pc0), .d_pcplus4(pc40), .d_valid(v0), .f_fault(f0)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst), .f_imem_A(a1), .f_imem_RD(rd1),
    .f_stall(stall), .f_flush(flush), .f_redirect(redir), .f_target(target),
    .d_instr(instr1), .d_pc(pc1), .d_pcplus4(pc41), .d_valid(v1), .f_fault(f1)
  );

  function automatic obs_t mk(input logic f, input logic v, input logic [31:0] a,
                              input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
    obs_t o;
    o.f = f; o.v = v; o.a = a; o.instr = i; o.pc = p; o.pc4 = p4;
    return o;
  endfunction

  function automatic obs_t cur0();
    return mk(f0, v0, a0, instr0, pc0, pc40);
  endfunction

  function automatic obs_t cur1();
    return mk(f1, v1, a1, instr1, pc1, pc41);
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic d,
                       input logic [31:0] t);
    rst = r; stall = s; flush = f; redir = d; target = t;
  endtask

  task automatic test_reset;
    obs_t got, e;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 32'h0, NOP, 32'h0, 32'h0));
      tick;
      got = cur0(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL reset step%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_boot;
    obs_t got, e;
    obs_t ex[3];
    ex[0] = mk(1'b0, 1'b0, 32'h0, NOP, 32'h0, 32'h0);
    ex[1] = mk(1'b0, 1'b1, 32'h4, mem(32'h0), 32'h0, 32'h4);
    ex[2] = mk(1'b0, 1'b1, 32'h8, mem(32'h4), 32'h4, 32'h8);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ex[i]);
      tick;
      got = cur0(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL boot edge%0d got=%h exp=%h", i + 1, got, e);
      end
    end
  endtask

  task automatic test_stall;
    obs_t got, e;
    obs_t ex[3];
    ex[0] = mk(1'b0, 1'b1, 32'h8, mem(32'h4), 32'h4, 32'h8);
    ex[1] = ex[0];
    ex[2] = mk(1'b0, 1'b1, 32'hC, mem(32'h8), 32'h8, 32'hC);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i < 2), 1'b0, 1'b0, 32'h0);
      exp_q.push_back(ex[i]);
      tick;
      got = cur0(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL stall step%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_redirect;
    obs_t got, e;
    logic [2:0]  ctl[5];
    logic [31:0] tgt[5];
    obs_t        ex[5];
    ctl[0] = 3'b001; tgt[0] = 32'h40;  ex[0] = mk(1'b0, 1'b0, 32'h40, NOP, 32'h8, 32'hC);
    ctl[1] = 3'b000; tgt[1] = 32'h0;   ex[1] = mk(1'b0, 1'b1, 32'h44, mem(32'h40), 32'h40, 32'h44);
    ctl[2] = 3'b101; tgt[2] = 32'h80;  ex[2] = mk(1'b0, 1'b0, 32'h80, NOP, 32'h40, 32'h44);
    ctl[3] = 3'b011; tgt[3] = 32'h100; ex[3] = mk(1'b0, 1'b0, 32'h100, NOP, 32'h40, 32'h44);
    ctl[4] = 3'b000; tgt[4] = 32'h0;   ex[4] = mk(1'b0, 1'b1, 32'h104, mem(32'h100), 32'h100, 32'h104);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, ctl[i][2], ctl[i][1], ctl[i][0], tgt[i]);
      exp_q.push_back(ex[i]);
      tick;
      got = cur0(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL redirect step%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_flush;
    obs_t got, e;
    logic [1:0] ctl[4];
    obs_t       ex[4];
    ctl[0] = 2'b11; ex[0] = mk(1'b0, 1'b0, 32'h104, NOP, 32'h100, 32'h104);
    ctl[1] = 2'b00; ex[1] = mk(1'b0, 1'b1, 32'h108, mem(32'h104), 32'h104, 32'h108);
    ctl[2] = 2'b01; ex[2] = mk(1'b0, 1'b0, 32'h10C, NOP, 32'h104, 32'h108);
    ctl[3] = 2'b00; ex[3] = mk(1'b0, 1'b1, 32'h110, mem(32'h10C), 32'h10C, 32'h110);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ctl[i][1], ctl[i][0], 1'b0, 32'h0);
      exp_q.push_back(ex[i]);
      tick;
      got = cur0(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL flush step%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_fault;
    obs_t        got, e;
    logic [2:0]  ctl;
    logic [31:0] tgt;
    for (int i = 0; i < 12; i++) begin
      ctl = 3'($urandom_range(0, 7));
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      if (i == 0) begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
      end else if (i == 11) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      end else begin
        drive(1'b0, ctl[2], ctl[1], ctl[0], tgt);
      end
      if (i == 11) exp_q.push_back(mk(1'b0, 1'b0, 32'h0, NOP, 32'h0, 32'h0));
      else         exp_q.push_back(mk(1'b1, 1'b0, 32'h110, NOP, 32'h10C, 32'h110));
      tick;
      got = cur0(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL fault step%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_wrap;
    obs_t got, e;
    obs_t ex[6];
    ex[0] = mk(1'b0, 1'b0, WRAP_PC, NOP, 32'h0, 32'h0);
    ex[1] = ex[0];
    ex[2] = ex[0];
    ex[3] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, mem(32'hFFFF_FFF8), 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    ex[4] = mk(1'b0, 1'b1, 32'h0000_0000, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0000_0000);
    ex[5] = mk(1'b0, 1'b1, 32'h0000_0004, mem(32'h0000_0000), 32'h0000_0000, 32'h0000_0004);
    for (int i = 0; i < 6; i++) begin
      drive((i < 2), 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(ex[i]);
      tick;
      got = cur1(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL wrap step%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    test_reset;
    test_boot;
    test_stall;
    test_redirect;
    test_flush;
    test_fault;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
